dist_ram_path: RTL and testbench
================================

DIST_RAM_PATH -- requirements
Module: dist_ram_path

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning pattern/data width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of RAM words (address width = log2(DEPTH) = 8).
REQ-003 SHALL have parameter THRESH, default 4, meaning maximum Hamming distance for a pattern to be accepted.
REQ-004 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high.
REQ-006 SHALL have port: a  input  WIDTH  incoming test pattern, one per cycle.
REQ-007 SHALL have port: addr  input  8  RAM address, shared by write and read.
REQ-008 SHALL have port: wr  input  1  RAM write enable.
REQ-009 SHALL have port: b  output  WIDTH  pattern delayed 1 cycle.
REQ-010 SHALL have port: c  output  WIDTH  pattern delayed 2 cycles.
REQ-011 SHALL have port: num  output  WIDTH  registered Hamming distance popcount(b XOR c).
REQ-012 SHALL have port: red_out  output  WIDTH  last accepted low-transition pattern.
REQ-013 SHALL have port: out  output  WIDTH  registered RAM read data.

Function
REQ-014 Buffer stage: each edge, b <= a and c <= b.
REQ-015 Distance stage: each edge, num <= popcount(b XOR c), computed from pre-edge b and c; range 0..WIDTH, zero-extended.
REQ-016 Filter: each edge, if popcount(b XOR c) <= THRESH then red_out <= b; otherwise red_out holds.
REQ-017 Latency: a sampled at edge k appears on b after edge k, on c after edge k+1, and is reflected in num/red_out after edge k+1.
REQ-018 Distance exactly THRESH SHALL be accepted; THRESH+1 SHALL be rejected.
REQ-019 RAM: DEPTH x WIDTH; at an edge with wr=1 and reset=0, mem[addr] <= red_out (the pre-edge value).
REQ-020 RAM read: each edge with reset=0, out <= mem[addr] regardless of wr; a simultaneous write and read of the same address SHALL return the old data (read-first).
REQ-021 Reading a never-written address SHALL return an unspecified value; the bench SHALL NOT check it.

Reset
REQ-022 While reset=1 at an edge, b, c, num, red_out and out SHALL be cleared to 0.
REQ-023 While reset=1, RAM writes SHALL be suppressed; RAM contents SHALL NOT be cleared and SHALL survive a reset.
REQ-024 Reset asserted mid-stream SHALL discard in-flight patterns; after deassertion the first comparison SHALL use b=c=0 history.

Structure
REQ-025 A shared package SHALL hold WIDTH, DEPTH and THRESH defaults and a popcount function.
REQ-026 The distance computation and filter SHALL be one sub-module named hamming_filter (inputs clk, reset, b, c; outputs num, red_out).
REQ-027 The buffer stage and RAM SHALL be implemented inline in dist_ram_path; the RAM SHALL be inferable as block memory.

Verification
REQ-028 Reset, then a=0x0F for 3 cycles -> b=c=0x0F, num=0, red_out=0x0F.
REQ-029 From REQ-028 state, drive a=0xF0 -> after the next edge, num=8 and red_out stays 0x0F (rejected).
REQ-030 Steady a=0x00, then a=0x0F for one cycle, then a=0x1F -> num=4, red_out=0x0F (boundary accepted); on the next edge num=1, red_out=0x1F.
REQ-031 With red_out=0x0F, wr=1, addr=10 for one edge, then wr=0, addr=10 -> out=0x0F one edge later.
REQ-032 Write 0x0F to addr 12, then wr=1, addr=12 with red_out=0x1F -> out=0x0F at that edge; at the next read edge, out=0x1F.
REQ-033 Write addr 20, then pulse reset with wr=1 -> outputs are 0 during reset, and afterwards the stored data at addr 20 is still readable and unchanged.

Source files
------------

// File: rtl/dist_ram_path_pkg.sv
// Shared defaults and helpers for the pattern-distance / RAM path.
package dist_ram_path_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 256;
    localparam int THRESH_DEF = 4;

    // Callers zero-extend their operand, so this serves any width up to 32.
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dist_ram_path_hamming_filter.sv
// Hamming distance between consecutive patterns, and a filter that keeps the
// most recent pattern whose distance is within THRESH.
module hamming_filter
    import dist_ram_path_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] red_out
);

    logic [31:0]      dist_p0;
    logic [WIDTH-1:0] num_p1;
    logic [WIDTH-1:0] red_p1;

    assign dist_p0 = popcount(32'(b ^ c));

    // stage p0 -> p1: distance register and accept filter
    always_ff @(posedge clk) begin
        if (reset) begin
            num_p1 <= '0;
            red_p1 <= '0;
        end else begin
            num_p1 <= dist_p0[WIDTH-1:0];
            if (dist_p0 <= 32'(THRESH)) begin
                red_p1 <= b;
            end
        end
    end

    assign num     = num_p1;
    assign red_out = red_p1;

endmodule

// File: rtl/dist_ram_path.sv
// Pattern delay line feeding a Hamming filter; accepted patterns can be stored
// into a read-first single-port RAM.
module dist_ram_path
    import dist_ram_path_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       addr,
    input  logic             wr,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] red_out,
    output logic [WIDTH-1:0] out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] c_p1;
    logic [WIDTH-1:0] rd_p0;
    logic [WIDTH-1:0] mem [DEPTH];

    // stage p0/p1: two-deep pattern delay line
    always_ff @(posedge clk) begin
        if (reset) begin
            b_p0 <= '0;
            c_p1 <= '0;
        end else begin
            b_p0 <= a;
            c_p1 <= b_p0;
        end
    end

    assign b = b_p0;
    assign c = c_p1;

    hamming_filter #(
        .WIDTH  (WIDTH),
        .THRESH (THRESH)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .b       (b_p0),
        .c       (c_p1),
        .num     (num),
        .red_out (red_out)
    );

    // Array is never reset so it maps onto block memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            mem[addr[AW-1:0]] <= red_out;
        end
    end

    // stage p0: registered read, old data on same-address write
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p0 <= '0;
        end else begin
            rd_p0 <= mem[addr[AW-1:0]];
        end
    end

    assign out = rd_p0;

endmodule

// File: tb/tb_dist_ram_path.sv
// Directed bench: stimulus queues hand-computed expectations tagged with the
// clock edge after which they hold; a monitor retires them on the falling edge.
module tb_dist_ram_path;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] b, c, num, red_out, out;

    dist_ram_path dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .addr    (addr),
        .wr      (wr),
        .b       (b),
        .c       (c),
        .num     (num),
        .red_out (red_out),
        .out     (out)
    );

    always #5 clk = ~clk;

    localparam int SB = 0, SC = 1, SN = 2, SR = 3, SO = 4;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic logic [7:0] pick(input int sig);
        case (sig)
            SB:      return b;
            SC:      return c;
            SN:      return num;
            SR:      return red_out;
            default: return out;
        endcase
    endfunction

    // Monitor: retire every expectation due after the edge just taken.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= edges) begin
            exp_t e;
            logic [7:0] got;
            e = sbq.pop_front();
            got = pick(e.sig);
            checks++;
            if (e.cyc < edges) begin
                errors++;
                $display("FAIL %s: check missed its edge %0d (now %0d)", e.nm, e.cyc, edges);
            end else if (got !== e.val) begin
                errors++;
                $display("FAIL %s: edge %0d got %h expected %h", e.nm, edges, got, e.val);
            end
        end
    end

    task automatic apply(input logic [7:0] ai, input logic [7:0] ad, input logic w, input logic r);
        a = ai; addr = ad; wr = w; reset = r;
    endtask

    task automatic expect_v(input int sig, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc = edges + 1; e.sig = sig; e.val = v; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // reset clears every output
        apply(8'hAA, 8'd0, 1'b0, 1'b1);
        expect_v(SB, 8'h00, "rst_b");
        expect_v(SC, 8'h00, "rst_c");
        expect_v(SN, 8'h00, "rst_num");
        expect_v(SR, 8'h00, "rst_red");
        expect_v(SO, 8'h00, "rst_out");
        tick();
        apply(8'h55, 8'd0, 1'b1, 1'b1);
        tick();

        // steady 0x0F: latency and settled state
        apply(8'h0F, 8'd0, 1'b0, 1'b0);
        expect_v(SB, 8'h0F, "lat_b");
        expect_v(SC, 8'h00, "lat_c");
        tick();
        expect_v(SN, 8'h04, "fill_num");
        expect_v(SR, 8'h0F, "fill_red");
        tick();
        expect_v(SB, 8'h0F, "st_b");
        expect_v(SC, 8'h0F, "st_c");
        expect_v(SN, 8'h00, "st_num");
        expect_v(SR, 8'h0F, "st_red");
        tick();

        // 0x0F -> 0xF0 is distance 8: rejected
        apply(8'hF0, 8'd0, 1'b0, 1'b0);
        expect_v(SB, 8'hF0, "rej_b");
        expect_v(SC, 8'h0F, "rej_c");
        expect_v(SN, 8'h00, "rej_num0");
        tick();
        expect_v(SN, 8'h08, "rej_num8");
        expect_v(SR, 8'h0F, "rej_hold");
        tick();

        // 0xF0 -> 0x00 is distance 4 (accepted), then 0x00 -> 0x0F -> 0x1F
        apply(8'h00, 8'd0, 1'b0, 1'b0);
        tick();
        expect_v(SN, 8'h04, "acc4_num");
        expect_v(SR, 8'h00, "acc4_red");
        tick();
        tick();
        apply(8'h0F, 8'd0, 1'b0, 1'b0);
        tick();
        apply(8'h1F, 8'd0, 1'b0, 1'b0);
        expect_v(SN, 8'h04, "bnd_num");
        expect_v(SR, 8'h0F, "bnd_red");
        tick();

        // store red_out=0x0F at addr 10, read it back
        apply(8'h1F, 8'd10, 1'b1, 1'b0);
        expect_v(SN, 8'h01, "d1_num");
        expect_v(SR, 8'h1F, "d1_red");
        tick();
        apply(8'h1F, 8'd10, 1'b0, 1'b0);
        expect_v(SO, 8'h0F, "ram10_rd");
        tick();

        // 0x1F -> 0x00 is distance 5: rejected
        apply(8'h00, 8'd10, 1'b0, 1'b0);
        tick();
        expect_v(SN, 8'h05, "rej5_num");
        expect_v(SR, 8'h1F, "rej5_hold");
        tick();
        apply(8'h0F, 8'd10, 1'b0, 1'b0);
        tick();
        apply(8'h1F, 8'd10, 1'b0, 1'b0);
        expect_v(SR, 8'h0F, "re0f_red");
        tick();

        // read-first: 0x0F to addr 12, then overwrite with 0x1F while reading
        apply(8'h1F, 8'd12, 1'b1, 1'b0);
        tick();
        apply(8'h1F, 8'd12, 1'b1, 1'b0);
        expect_v(SO, 8'h0F, "rf_old");
        tick();
        apply(8'h1F, 8'd12, 1'b0, 1'b0);
        expect_v(SO, 8'h1F, "rf_new");
        tick();

        // store 0x1F at addr 20, then reset with wr held high
        apply(8'h1F, 8'd20, 1'b1, 1'b0);
        tick();
        apply(8'hAA, 8'd20, 1'b1, 1'b1);
        expect_v(SB, 8'h00, "mr_b");
        expect_v(SC, 8'h00, "mr_c");
        expect_v(SN, 8'h00, "mr_num");
        expect_v(SR, 8'h00, "mr_red");
        expect_v(SO, 8'h00, "mr_out");
        tick();
        apply(8'hAA, 8'd20, 1'b1, 1'b1);
        expect_v(SO, 8'h00, "mr_out2");
        tick();

        // after reset: RAM kept, pipeline history is zero
        apply(8'h3C, 8'd20, 1'b0, 1'b0);
        expect_v(SO, 8'h1F, "keep20");
        expect_v(SB, 8'h3C, "post_b");
        expect_v(SC, 8'h00, "post_c");
        expect_v(SN, 8'h00, "post_num0");
        expect_v(SR, 8'h00, "post_red0");
        tick();
        expect_v(SN, 8'h04, "post_num4");
        expect_v(SR, 8'h3C, "post_red");
        expect_v(SO, 8'h1F, "keep20b");
        tick();

        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
